// File: rtl/stack_sequencer_pkg.sv
// Purpose: shared constants, opcode encodings and FSM state type for the
//          stack sequencer (CALL/RET/RETI/interrupt stack handling).
// Contents: opcode constants, ISR vector, data/PC/flag widths, state and
//           sequence-kind enums.
package stack_sequencer_pkg;

   localparam int unsigned OPCODE_W = 5;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned PC_W     = 32;
   localparam int unsigned FLAG_W   = 3;

   localparam logic [OPCODE_W-1:0] OP_CALL = 5'd20;
   localparam logic [OPCODE_W-1:0] OP_RET  = 5'd21;
   localparam logic [OPCODE_W-1:0] OP_RETI = 5'd22;

   localparam logic [PC_W-1:0] ISR_VECTOR = 32'h0000_0020;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH_FLAGS,
      S_PUSH_HI,
      S_PUSH_LO,
      S_POP_LO,
      S_POP_HI,
      S_POP_FLAGS,
      S_FINISH
   } state_e;

   // Which sequence is in flight; selects the FINISH behaviour.
   typedef enum logic [1:0] {
      K_INT,
      K_CALL,
      K_RET,
      K_RETI
   } kind_e;

endpackage

// File: rtl/stack_sequencer.sv
// Purpose: sequences the data-memory stack traffic for CALL, RET, RETI and
//          interrupt entry, stalling the front end while it works and
//          redirecting the PC (and flags on RETI) when done.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   opcode, instr_valid       instruction in decode
//   pc_in, target_in          return/interrupted PC and CALL destination
//   flags_in                  current {C,N,Z}
//   irq                       level interrupt request
//   mem_rdata                 read data, valid the cycle after mem_read
//   mem_read, mem_write       data-memory strobes
//   mem_addr, mem_wdata       data-memory address and write data
//   sp                        current stack pointer
//   stall, flush              front-end freeze / squash decode
//   pc_load, pc_out           PC redirect strobe and value
//   flags_load, flags_out     flag restore strobe and value
module stack_sequencer
   import stack_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                instr_valid,
   input  logic [PC_W-1:0]     pc_in,
   input  logic [PC_W-1:0]     target_in,
   input  logic [FLAG_W-1:0]   flags_in,
   input  logic                irq,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [ADDR_W-1:0]   sp,
   output logic                stall,
   output logic                flush,
   output logic                pc_load,
   output logic [PC_W-1:0]     pc_out,
   output logic                flags_load,
   output logic [FLAG_W-1:0]   flags_out
);

   state_e              state_q, state_d;
   kind_e               kind_q, kind_d;
   logic [ADDR_W-1:0]   sp_q, sp_d;
   logic                irq_pending_q, irq_pending_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [PC_W-1:0]     target_q, target_d;
   logic [FLAG_W-1:0]   flags_q, flags_d;
   logic [DATA_W-1:0]   lo_q, lo_d;
   logic [DATA_W-1:0]   hi_q, hi_d;

   logic                int_req;
   logic                start;

   // State and capture registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         kind_q        <= K_INT;
         sp_q          <= {ADDR_W{1'b1}};
         irq_pending_q <= 1'b0;
         pc_q          <= '0;
         target_q      <= '0;
         flags_q       <= '0;
         lo_q          <= '0;
         hi_q          <= '0;
      end else begin
         state_q       <= state_d;
         kind_q        <= kind_d;
         sp_q          <= sp_d;
         irq_pending_q <= irq_pending_d;
         pc_q          <= pc_d;
         target_q      <= target_d;
         flags_q       <= flags_d;
         lo_q          <= lo_d;
         hi_q          <= hi_d;
      end
   end

   // Next-state, stack pointer update and output decode.
   always_comb begin
      state_d       = state_q;
      kind_d        = kind_q;
      sp_d          = sp_q;
      irq_pending_d = irq_pending_q | irq;
      pc_d          = pc_q;
      target_d      = target_q;
      flags_d       = flags_q;
      lo_d          = lo_q;
      hi_d          = hi_q;
      start         = 1'b0;

      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      stall         = 1'b0;
      flush         = 1'b0;
      pc_load       = 1'b0;
      pc_out        = '0;
      flags_load    = 1'b0;
      flags_out     = '0;

      // A request raised in this very cycle wins over a same-cycle CALL.
      int_req = irq_pending_q | irq;

      unique case (state_q)
         S_IDLE: begin
            if (int_req) begin
               start         = 1'b1;
               kind_d        = K_INT;
               state_d       = S_PUSH_FLAGS;
               irq_pending_d = 1'b0;
               flush         = 1'b1;
            end else if (instr_valid) begin
               if (opcode == OP_CALL) begin
                  start   = 1'b1;
                  kind_d  = K_CALL;
                  state_d = S_PUSH_HI;
               end else if (opcode == OP_RET) begin
                  start   = 1'b1;
                  kind_d  = K_RET;
                  state_d = S_POP_LO;
               end else if (opcode == OP_RETI) begin
                  start   = 1'b1;
                  kind_d  = K_RETI;
                  state_d = S_POP_LO;
               end
            end
         end
         S_PUSH_FLAGS: begin
            mem_write = 1'b1;
            mem_addr  = sp_q;
            mem_wdata = DATA_W'(flags_q);
            sp_d      = sp_q - ADDR_W'(1);
            state_d   = S_PUSH_HI;
         end
         S_PUSH_HI: begin
            mem_write = 1'b1;
            mem_addr  = sp_q;
            mem_wdata = pc_q[PC_W-1:DATA_W];
            sp_d      = sp_q - ADDR_W'(1);
            state_d   = S_PUSH_LO;
         end
         S_PUSH_LO: begin
            mem_write = 1'b1;
            mem_addr  = sp_q;
            mem_wdata = pc_q[DATA_W-1:0];
            sp_d      = sp_q - ADDR_W'(1);
            state_d   = S_FINISH;
         end
         S_POP_LO: begin
            mem_read = 1'b1;
            mem_addr = sp_q + ADDR_W'(1);
            sp_d     = sp_q + ADDR_W'(1);
            state_d  = S_POP_HI;
         end
         S_POP_HI: begin
            mem_read = 1'b1;
            mem_addr = sp_q + ADDR_W'(1);
            sp_d     = sp_q + ADDR_W'(1);
            lo_d     = mem_rdata;
            state_d  = (kind_q == K_RETI) ? S_POP_FLAGS : S_FINISH;
         end
         S_POP_FLAGS: begin
            mem_read = 1'b1;
            mem_addr = sp_q + ADDR_W'(1);
            sp_d     = sp_q + ADDR_W'(1);
            hi_d     = mem_rdata;
            state_d  = S_FINISH;
         end
         S_FINISH: begin
            pc_load = 1'b1;
            state_d = S_IDLE;
            unique case (kind_q)
               K_INT:  pc_out = ISR_VECTOR;
               K_CALL: pc_out = target_q;
               // RET's high half is still on the read bus this cycle.
               K_RET:  pc_out = {mem_rdata, lo_q};
               K_RETI: begin
                  pc_out     = {hi_q, lo_q};
                  flags_load = 1'b1;
                  flags_out  = mem_rdata[FLAG_W-1:0];
               end
               default: pc_out = '0;
            endcase
         end
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         pc_d     = pc_in;
         target_d = target_in;
         flags_d  = flags_in;
      end

      if (state_q != S_IDLE) begin
         stall = 1'b1;
      end

      // Reset silences the interface in the cycle it is applied.
      if (rst) begin
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         mem_addr   = '0;
         mem_wdata  = '0;
         stall      = 1'b0;
         flush      = 1'b0;
         pc_load    = 1'b0;
         pc_out     = '0;
         flags_load = 1'b0;
         flags_out  = '0;
      end
   end

   assign sp = sp_q;

endmodule
